// File: rtl/magnetron_pkg.sv
// magnetron_pkg: shared state encoding and default parameters for the magnetron SR driver
package magnetron_pkg;
    typedef logic [2:0] state_t;
    localparam int DEF_CLK_PER_SEC = 50_000_000;
    localparam int DEF_TIME_W = 8;
    localparam int DEF_PULSE_W = 2;
    localparam state_t ST_CLEAR = 3'd0;
    localparam state_t ST_IDLE  = 3'd1;
    localparam state_t ST_SET   = 3'd2;
    localparam state_t ST_COOK  = 3'd3;
    localparam state_t ST_RESET = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_FAULT = 3'd6;
endpackage

// File: rtl/magnetron_sr_driver_sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle tick per cook second
module sec_prescaler
    import magnetron_pkg::*;
#(
    parameter int CLK_PER_SEC = DEF_CLK_PER_SEC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = CLK_PER_SEC > 1 ? $clog2(CLK_PER_SEC) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(CLK_PER_SEC - 1);
    // count 0..CLK_PER_SEC-1 while enabled, wrapping on the tick
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/magnetron_sr_driver.sv
// magnetron_sr_driver: sequences s/r pulses to the magnetron SR latch, runs the cook countdown, checks q feedback
module magnetron_sr_driver
    import magnetron_pkg::*;
#(
    parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
    parameter int TIME_W = DEF_TIME_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              door_closed,
    input  logic [TIME_W-1:0] cook_time,
    input  logic              q_fb,
    output logic              s,
    output logic              r,
    output logic              cooking,
    output logic [TIME_W-1:0] remaining,
    output logic              done,
    output logic              fault
);
    localparam int PCW = $clog2(PULSE_W + 1);
    state_t state, state_n;
    logic [PCW-1:0] pcnt;
    logic expired, tick, pulse_last, accept, abort, dec;
    logic s_d, r_d, cooking_d, done_d, fault_d;
    assign pulse_last = pcnt == PCW'(PULSE_W - 1);
    assign accept = start && door_closed && !stop && cook_time != '0;
    assign abort = !door_closed || stop;
    assign dec = state == ST_COOK && q_fb && !abort && tick;
    sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_pre (
        .clk(clk),
        .rst(rst),
        .clr(state != ST_COOK),
        .en(state == ST_COOK),
        .tick(tick)
    );
    // state, pulse counter (reloaded on every state change), countdown and expiry flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            pcnt <= '0;
            remaining <= '0;
            expired <= 1'b0;
        end else begin
            state <= state_n;
            pcnt <= state_n != state ? '0 : pcnt + 1'b1;
            if (state == ST_IDLE && accept) remaining <= cook_time;
            else if (dec) remaining <= remaining - 1'b1;
            if (state == ST_COOK && state_n == ST_RESET) expired <= !abort;
        end
    end
    // next state; in COOK a lost latch wins over door, stop and expiry in that order
    always_comb begin
        state_n = state;
        case (state)
            ST_CLEAR: state_n = pulse_last ? ST_IDLE : ST_CLEAR;
            ST_IDLE:  state_n = accept ? ST_SET : ST_IDLE;
            ST_SET:   state_n = !pulse_last ? ST_SET : q_fb ? ST_COOK : ST_FAULT;
            ST_COOK:  state_n = !q_fb ? ST_FAULT :
                                (abort || (tick && remaining == TIME_W'(1))) ? ST_RESET : ST_COOK;
            ST_RESET: state_n = !pulse_last ? ST_RESET : q_fb ? ST_FAULT : expired ? ST_DONE : ST_IDLE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_FAULT;
        endcase
    end
    // output decode; s and r come from mutually exclusive states so both can never be high
    always_comb begin
        s_d = state == ST_SET;
        r_d = state == ST_CLEAR || state == ST_RESET || state == ST_FAULT;
        cooking_d = state == ST_COOK;
        done_d = state == ST_DONE;
        fault_d = state == ST_FAULT;
    end
    // registered outputs; reset holds the latch cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 1'b0;
            r <= 1'b1;
            cooking <= 1'b0;
            done <= 1'b0;
            fault <= 1'b0;
        end else begin
            s <= s_d;
            r <= r_d;
            cooking <= cooking_d;
            done <= done_d;
            fault <= fault_d;
        end
    end
endmodule
